// File: rtl/alu_stage_pkg.sv
// rtl/alu_stage_pkg.sv - shared micro-op codes, flag indices and execute-stage state type
package Utilities;

    localparam logic [4:0] NOP = 5'd0;
    localparam logic [4:0] ADD = 5'd1;
    localparam logic [4:0] SUB = 5'd2;
    localparam logic [4:0] CMP = 5'd3;
    localparam logic [4:0] AND = 5'd4;
    localparam logic [4:0] ORR = 5'd5;
    localparam logic [4:0] EOR = 5'd6;
    localparam logic [4:0] MOV = 5'd7;
    localparam logic [4:0] LSL = 5'd8;
    localparam logic [4:0] LSR = 5'd9;
    localparam logic [4:0] MUL = 5'd10;
    localparam logic [4:0] STR = 5'd11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // MUL_BUSY is the iterative-multiply state; the bare name MUL is taken by the uop code.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_stage_seq_multiplier.sv
// rtl/alu_stage_seq_multiplier.sv - 32x32 shift-add multiplier, one multiplier bit per clock
module seq_multiplier (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] product
);

    logic [4:0]  count;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;

    // product is the accumulator after the current iteration, so the final value is
    // available combinationally in the same cycle that done is raised
    assign product = acc + (mplier[0] ? mcand : 32'd0);
    assign done    = busy && (count == 5'd31);

    // load operands on start, then add/shift once per clock for 32 clocks
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count  <= 5'd0;
            acc    <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            busy   <= 1'b0;
        end else if (start) begin
            count  <= 5'd0;
            acc    <= 32'd0;
            mcand  <= a;
            mplier <= b;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - execute stage: single-cycle ALU, iterative MUL, one commit cycle per op
module alu_stage
    import Utilities::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  uop,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  flags_in,
    output logic [31:0] result,
    output logic [3:0]  flags_out,
    output logic [4:0]  out_uop,
    output logic        rf_not_enable
);

    alu_state_t  state;
    alu_state_t  next_state;
    logic        accept;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_product;
    logic [1:0]  mul_cv;

    logic [32:0] sum33;
    logic [31:0] diff;
    logic [32:0] shl;
    logic [32:0] shr;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;
    logic [4:0]  alu_uop;
    logic        alu_c;
    logic        alu_v;
    logic        alu_nz;

    assign in_ready  = (state == IDLE) || (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (uop == MUL);

    seq_multiplier u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next state: accepted ops go to DONE or MUL_BUSY, an unused DONE falls back to IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    next_state = (uop == MUL) ? MUL_BUSY : DONE;
                end else if (state == DONE) begin
                    next_state = IDLE;
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // single-cycle datapath; undefined codes become NOP and keep result and flags
    always_comb begin
        sum33   = {1'b0, op_a} + {1'b0, op_b};
        diff    = op_a - op_b;
        shl     = {1'b0, op_a} << op_b[4:0];
        shr     = {op_a, 1'b0} >> op_b[4:0];
        alu_res = result;
        alu_uop = uop;
        alu_c   = flags_in[FLAG_C];
        alu_v   = flags_in[FLAG_V];
        alu_nz  = 1'b1;
        case (uop)
            ADD: begin
                alu_res = sum33[31:0];
                alu_c   = sum33[32];
                alu_v   = (op_a[31] == op_b[31]) && (sum33[31] != op_a[31]);
            end
            SUB, CMP: begin
                alu_res = diff;
                alu_c   = (op_a >= op_b);
                alu_v   = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            end
            AND: alu_res = op_a & op_b;
            ORR: alu_res = op_a | op_b;
            EOR: alu_res = op_a ^ op_b;
            MOV: alu_res = op_b;
            LSL: begin
                alu_res = shl[31:0];
                if (op_b[4:0] != 5'd0) begin
                    alu_c = shl[32];
                end
            end
            LSR: begin
                alu_res = shr[32:1];
                if (op_b[4:0] != 5'd0) begin
                    alu_c = shr[0];
                end
            end
            STR: begin
                alu_res = sum33[31:0];
                alu_nz  = 1'b0;
            end
            default: begin
                alu_uop = NOP;
                alu_nz  = 1'b0;
            end
        endcase
        alu_flags = alu_nz ? {alu_res[31], (alu_res == 32'd0), alu_c, alu_v} : flags_in;
    end

    // commit registers: loaded on single-cycle accept or on the last MUL iteration
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            result        <= 32'd0;
            flags_out     <= 4'd0;
            out_uop       <= NOP;
            rf_not_enable <= 1'b1;
            mul_cv        <= 2'd0;
        end else begin
            rf_not_enable <= (next_state != DONE);
            if (mul_start) begin
                mul_cv <= flags_in[FLAG_C:FLAG_V];
            end
            if (accept && (uop != MUL)) begin
                result    <= alu_res;
                flags_out <= alu_flags;
                out_uop   <= alu_uop;
            end else if ((state == MUL_BUSY) && mul_done) begin
                result    <= mul_product;
                flags_out <= {mul_product[31], (mul_product == 32'd0), mul_cv};
                out_uop   <= MUL;
            end
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - self-checking bench for alu_stage
module tb_alu_stage;
    import Utilities::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  uop = NOP;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [3:0]  flags_in = 4'd0;
    logic [31:0] result;
    logic [3:0]  flags_out;
    logic [4:0]  out_uop;
    logic        rf_not_enable;

    int total = 0;
    int bad = 0;
    logic [31:0] m_result = 32'd0;

    always #5 clock = ~clock;

    alu_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .uop           (uop),
        .op_a          (op_a),
        .op_b          (op_b),
        .flags_in      (flags_in),
        .result        (result),
        .flags_out     (flags_out),
        .out_uop       (out_uop),
        .rf_not_enable (rf_not_enable)
    );

    typedef struct {
        logic [4:0]  u;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fl;
        logic [31:0] er;
        logic [3:0]  ef;
        logic [4:0]  eu;
        int          lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // reference: arithmetic on wide integers, overflow as "sign-extended result differs from exact sum"
    function automatic void model(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fl, input logic [31:0] prev,
                                  output logic [31:0] r, output logic [3:0] f, output logic [4:0] ou);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        int              sh = int'(b[4:0]);
        logic            c = fl[1];
        logic            v = fl[0];
        logic            nz = 1'b1;
        ou = u;
        r = prev;
        case (u)
            ADD: begin
                r = 32'(ua + ub);
                c = ((ua + ub) >> 32) != 0;
                v = (sa + sb) != longint'($signed(r));
            end
            SUB, CMP: begin
                r = 32'(ua - ub);
                c = ua >= ub;
                v = (sa - sb) != longint'($signed(r));
            end
            AND: r = a & b;
            ORR: r = a | b;
            EOR: r = a ^ b;
            MOV: r = b;
            LSL: begin
                r = 32'(ua << sh);
                if (sh != 0) c = ((ua >> (32 - sh)) & 64'd1) != 0;
            end
            LSR: begin
                r = 32'(ua >> sh);
                if (sh != 0) c = ((ua >> (sh - 1)) & 64'd1) != 0;
            end
            MUL: r = 32'(ua * ub);
            STR: begin
                r = 32'(ua + ub);
                nz = 1'b0;
            end
            default: begin
                ou = NOP;
                nz = 1'b0;
            end
        endcase
        f = nz ? {r[31], r == 32'd0, c, v} : fl;
    endfunction

    // issue one op, scramble inputs after acceptance, wait (bounded) for the commit cycle
    task automatic run_op(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] fl, output logic [31:0] r, output logic [3:0] f,
                          output logic [4:0] ou, output int lat, output int busy);
        int guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        uop = u; op_a = a; op_b = b; flags_in = fl; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        uop = 5'($urandom); op_a = $urandom; op_b = $urandom; flags_in = 4'($urandom);
        lat = 1;
        busy = 0;
        while (rf_not_enable && lat < 40) begin
            if (!in_ready) busy++;
            @(negedge clock);
            lat++;
        end
        r = result; f = flags_out; ou = out_uop;
    endtask

    task automatic check_op(input string name, input logic [4:0] u, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] fl, input logic [31:0] er,
                            input logic [3:0] ef, input logic [4:0] eu, input int elat);
        logic [31:0] r;
        logic [3:0]  f;
        logic [4:0]  ou;
        int          lat;
        int          busy;
        run_op(u, a, b, fl, r, f, ou, lat, busy);
        chk({name, " result"}, r, er);
        chk({name, " flags"}, 32'(f), 32'(ef));
        chk({name, " uop"}, 32'(ou), 32'(eu));
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " busy_cycles"}, 32'(busy), 32'(elat - 1));
        @(negedge clock);
        chk({name, " single_commit"}, 32'(rf_not_enable), 32'd1);
    endtask

    initial begin
        vt[0]  = '{ADD, 32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 4'b1001, ADD, 1};
        vt[1]  = '{CMP, 32'd5, 32'd5, 4'b0000, 32'h00000000, 4'b0110, CMP, 1};
        vt[2]  = '{SUB, 32'd3, 32'd5, 4'b0000, 32'hFFFFFFFE, 4'b1000, SUB, 1};
        vt[3]  = '{MUL, 32'h0000FFFF, 32'h00010001, 4'b0011, 32'hFFFFFFFF, 4'b1011, MUL, 33};
        vt[4]  = '{LSL, 32'h80000001, 32'd1, 4'b0000, 32'h00000002, 4'b0010, LSL, 1};
        vt[5]  = '{LSL, 32'h12345678, 32'h20, 4'b0010, 32'h12345678, 4'b0010, LSL, 1};
        vt[6]  = '{NOP, 32'd0, 32'd0, 4'b1010, 32'h12345678, 4'b1010, NOP, 1};
        vt[7]  = '{LSR, 32'd3, 32'd1, 4'b0000, 32'h00000001, 4'b0010, LSR, 1};
        vt[8]  = '{EOR, 32'h5A5A5A5A, 32'h5A5A5A5A, 4'b1111, 32'h00000000, 4'b0111, EOR, 1};
        vt[9]  = '{STR, 32'h100, 32'h20, 4'b0101, 32'h00000120, 4'b0101, STR, 1};
        vt[10] = '{5'd31, 32'hFFFF, 32'hFFFF, 4'b1010, 32'h00000120, 4'b1010, NOP, 1};
        vt[11] = '{AND, 32'hFFFF0000, 32'h0F0F0F0F, 4'b0000, 32'h0F0F0000, 4'b0000, AND, 1};
        vt[12] = '{ORR, 32'd0, 32'd0, 4'b1100, 32'h00000000, 4'b0100, ORR, 1};
        vt[13] = '{ADD, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h00000000, 4'b0110, ADD, 1};
        vt[14] = '{MOV, 32'd0, 32'h80000000, 4'b0000, 32'h80000000, 4'b1000, MOV, 1};

        // reset state, with in_valid asserted to show it is ignored
        uop = ADD; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset rf_not_enable", 32'(rf_not_enable), 32'd1);
        chk("reset result", result, 32'd0);
        chk("reset flags", 32'(flags_out), 32'd0);
        chk("reset uop", 32'(out_uop), 32'(NOP));
        reset_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        chk("post-reset no commit", 32'(rf_not_enable), 32'd1);

        for (int i = 0; i < NV; i++) begin
            check_op($sformatf("vec%0d", i), vt[i].u, vt[i].a, vt[i].b, vt[i].fl,
                     vt[i].er, vt[i].ef, vt[i].eu, vt[i].lat);
        end
        m_result = vt[NV-1].er;

        // randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [4:0]  u;
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  fl;
            logic [31:0] er;
            logic [3:0]  ef;
            logic [4:0]  eu;
            u  = 5'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 33)) : $urandom;
            fl = 4'($urandom);
            model(u, a, b, fl, m_result, er, ef, eu);
            check_op($sformatf("rand%0d", i), u, a, b, fl, er, ef, eu, (u == MUL) ? 33 : 1);
            m_result = er;
        end

        // five back-to-back ADDs with in_valid held high
        begin
            logic [31:0] er;
            logic [3:0]  ef;
            logic [4:0]  eu;
            @(negedge clock);
            for (int i = 0; i < 5; i++) begin
                uop = ADD; op_a = $urandom; op_b = $urandom; flags_in = 4'($urandom);
                in_valid = 1'b1;
                model(ADD, op_a, op_b, flags_in, m_result, er, ef, eu);
                m_result = er;
                @(negedge clock);
                chk($sformatf("b2b%0d commit", i), 32'(rf_not_enable), 32'd0);
                chk($sformatf("b2b%0d result", i), result, er);
                chk($sformatf("b2b%0d flags", i), 32'(flags_out), 32'(ef));
                chk($sformatf("b2b%0d in_ready", i), 32'(in_ready), 32'd1);
            end
            in_valid = 1'b0;
            @(negedge clock);
            chk("b2b end", 32'(rf_not_enable), 32'd1);
        end

        // reset during MUL iteration 10 discards the op
        begin
            int commits = 0;
            @(negedge clock);
            uop = MUL; op_a = 32'h1234; op_b = 32'h5678; flags_in = 4'b1111; in_valid = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            chk("mul busy", 32'(in_ready), 32'd0);
            repeat (9) @(negedge clock);
            reset_n = 1'b0;
            uop = ADD; in_valid = 1'b1;
            @(negedge clock);
            chk("abort rf_not_enable", 32'(rf_not_enable), 32'd1);
            chk("abort uop", 32'(out_uop), 32'(NOP));
            chk("abort result", result, 32'd0);
            chk("abort flags", 32'(flags_out), 32'd0);
            chk("abort in_ready", 32'(in_ready), 32'd1);
            reset_n = 1'b1;
            in_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (!rf_not_enable) commits++;
            end
            chk("abort no commit", 32'(commits), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_stage.md
# alu_stage

Execute stage of the CPU datapath, placed directly downstream of the register file. It accepts one decoded micro-op per handshake together with the two operands read from the register file ports. It computes a 32-bit result and the NZCV flags, then drives the register file's write port (`in_reg`, `in_flags`, `uop`, `not_enable`) for exactly one commit cycle. Single-cycle ALU ops sustain one op per clock. MUL is iterative and stalls the handshake while it runs.

## Interface
- No parameters; data width is fixed at 32 bits and flags at 4 bits (NZCV).
- `clock` in 1 — single clock; all state updates on the posedge.
- `reset_n` in 1 — synchronous, active-low reset.
- `in_valid` in 1 — `uop`, `op_a`, `op_b` and `flags_in` are valid this cycle.
- `in_ready` out 1 — the stage accepts an op at this posedge when `in_valid` is also high.
- `uop` in 5 — micro-op code, encoded with the shared `Utilities` constants.
- `op_a`, `op_b` in 32 — operands, taken from register file `p0` and `p1`.
- `flags_in` in 4 — current flags, taken from register file `out_flags`; [3]=N, [2]=Z, [1]=C, [0]=V.
- `result` out 32 — goes to register file `in_reg`.
- `flags_out` out 4 — goes to register file `in_flags`.
- `out_uop` out 5 — goes to register file `uop`.
- `rf_not_enable` out 1 — goes to register file `not_enable`; low only during a commit cycle.

## Operation
- States: IDLE, MUL, DONE.
  - IDLE → DONE when a single-cycle op is accepted.
  - IDLE → MUL when a MUL op is accepted.
  - MUL → DONE after 32 iterations.
  - DONE → DONE if a single-cycle op is accepted, DONE → MUL if a MUL is accepted, otherwise DONE → IDLE.
- `in_ready` = (state == IDLE or DONE), combinational from the state.
- A commit cycle is any cycle spent in DONE. During it:
  - `rf_not_enable` = 0;
  - `result`, `flags_out` and `out_uop` are stable registered values.
- Per-op behaviour (`uop` → `result` / flags):
  - ADD: a+b. N, Z from the result; C = carry out; V = signed overflow.
  - SUB, CMP: a−b. C = 1 when a ≥ b unsigned (no borrow); V = signed overflow. CMP still commits; the register file suppresses the register write.
  - AND, ORR, EOR: logical op on a and b. MOV: b. For all four, N and Z come from the result and C, V are copied from `flags_in`.
  - LSL, LSR: a shifted by `op_b[4:0]`. C = the last bit shifted out; if the shift amount is 0, C is copied from `flags_in`. N, Z from the result; V from `flags_in`.
  - MUL: low 32 bits of a×b, computed by shift-add, one multiplier bit per cycle. N, Z from the result; C, V from `flags_in`.
  - STR: a+b (address). `flags_out` = `flags_in`.
  - NOP and any undefined code: `out_uop` = NOP, `result` unchanged, `flags_out` = `flags_in`. This still takes a commit cycle; the register file ignores it.
- Operands and `flags_in` are captured at acceptance. Changes on the inputs afterwards have no effect on the op in flight.
- `in_valid` while `in_ready` is 0 is ignored; upstream holds the op until it is accepted.

## Timing
- Single-cycle op accepted at posedge k: commit cycle runs from posedge k to posedge k+1.
- MUL accepted at posedge k:
  - iterations happen at posedges k+1 … k+32;
  - commit cycle runs from posedge k+32 to posedge k+33;
  - `in_ready` = 0 from posedge k to posedge k+32.
- The register file writes on the negedge inside the commit cycle, so outputs must be settled by mid-cycle. All outputs are flop-driven except `in_ready`.
- Reset (`reset_n` = 0 at a posedge), from any state including mid-MUL:
  - state → IDLE, iteration counter → 0;
  - `result` = 0, `flags_out` = 0, `out_uop` = NOP, `rf_not_enable` = 1;
  - the in-flight op is discarded without a commit;
  - `in_ready` reads 1 from the first cycle after reset.
- While `reset_n` = 0, `in_valid` is ignored.
- Back-to-back: with `in_valid` held high for single-cycle ops, there is one commit per clock and no bubble.

## Structure
- Add to package `Utilities`:
  - uop constants ADD, SUB, AND, ORR, EOR, MOV, LSL, LSR, MUL, alongside the existing NOP, CMP, STR;
  - flag bit index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  - enum typedef `alu_state_t` {IDLE, MUL, DONE}.
- One sub-module, `seq_multiplier`. It has:
  - start, a, b inputs;
  - a 5-bit counter, a 32-bit accumulator and a shifting multiplier register;
  - done and product outputs.
- `alu_stage` instantiates `seq_multiplier` and owns the FSM and the single-cycle datapath.

## Test plan
- ADD, a=0x7FFFFFFF, b=0x1 → next cycle: `result` = 0x80000000, `flags_out` = 4'b1001, `rf_not_enable` = 0 for exactly 1 cycle.
- CMP, a=5, b=5 → `result` = 0, `flags_out` = 4'b0110, `out_uop` = CMP. SUB, a=3, b=5 → `result` = 0xFFFFFFFE, `flags_out` = 4'b1000.
- MUL, a=0x0000FFFF, b=0x00010001, `flags_in` = 4'b0011 → `in_ready` low for 32 cycles; commit at k+32 with `result` = 0xFFFFFFFF and `flags_out` = 4'b1011.
- LSL, a=0x80000001, b=1 → `result` = 0x00000002 with C = 1. LSL, b=0, `flags_in` C=1 → C stays 1 and `result` = a.
- Five back-to-back ADDs with `in_valid` held high → five consecutive commit cycles, `rf_not_enable` low continuously, results in order.
- `reset_n` low during MUL iteration 10 → next cycle: IDLE, `rf_not_enable` = 1, `out_uop` = NOP, `result` = 0; no commit follows.
